// File: rtl/rxecrc_pkg.sv
// rxecrc_pkg: shared constants and types for the Ethernet RX nibble CRC-32
// checker/stripper and its CRC helper.
//   CRC_POLY    reflected CRC-32 polynomial
//   CRC_INIT    CRC register preset at frame start
//   CRC_RESIDUE register value after data+FCS of a good frame
//   rxc_state_t checker state encoding
package rxecrc_pkg;

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    // Nibbles held back so the trailing FCS is never forwarded.
    localparam logic [3:0]  LINE_LAST   = 4'd7;

    typedef enum logic [1:0] {
        RXC_IDLE   = 2'd0,
        RXC_FILL   = 2'd1,
        RXC_STREAM = 2'd2,
        RXC_BYPASS = 2'd3   // i_en=0 frame: pass-through, no check
    } rxc_state_t;

endpackage

// File: rtl/rxecrc_if.sv
// rxecrc_if: nibble-stream bundle between the RX front end, the CRC
// checker and the memory-write stage.
//   i_ce      nibble-rate clock enable
//   i_en      1 = check and strip FCS, 0 = bypass
//   i_cancel  abort current frame
//   i_v/i_d   input nibble valid / data (LSN first)
//   o_v/o_d   output nibble valid / data
//   o_done    frame ended normally (one ce-cycle pulse)
//   o_err     with o_done: FCS bad or runt
// master drives the i_* side and observes o_*; slave is the checker.
interface rxecrc_if;
    logic       i_ce;
    logic       i_en;
    logic       i_cancel;
    logic       i_v;
    logic [3:0] i_d;
    logic       o_v;
    logic [3:0] o_d;
    logic       o_done;
    logic       o_err;

    modport master (
        output i_ce, i_en, i_cancel, i_v, i_d,
        input  o_v, o_d, o_done, o_err
    );

    modport slave (
        input  i_ce, i_en, i_cancel, i_v, i_d,
        output o_v, o_d, o_done, o_err
    );
endinterface

// File: rtl/rxecrc_crc32_nib.sv
// rxecrc_crc32_nib: combinational CRC-32 update by one nibble, bit 0 first,
// reflected polynomial. Shared with the TX FCS generator.
//   i_crc  current CRC register
//   i_nib  nibble to absorb
//   o_crc  updated CRC register
module rxecrc_crc32_nib
    import rxecrc_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [3:0]  i_nib,
    output logic [31:0] o_crc
);

    logic [31:0] w_crc;
    logic        w_fb;

    always_comb begin
        w_crc = i_crc;
        w_fb  = 1'b0;
        for (int b = 0; b < 4; b++) begin
            w_fb  = w_crc[0] ^ i_nib[b];
            w_crc = {1'b0, w_crc[31:1]} ^ (w_fb ? CRC_POLY : 32'h0);
        end
        o_crc = w_crc;
    end

endmodule

// File: rtl/rxecrc.sv
// rxecrc: Ethernet RX nibble-stream CRC-32 checker/stripper. Holds the last
// 8 nibbles in a delay line so the FCS is absorbed by the CRC but never
// forwarded; flags bad FCS or runt frames at end of frame.
//   i_clk      system clock
//   i_reset_n  asynchronous active-low reset
//   s          rxecrc_if.slave stream bundle (see rxecrc_if)
module rxecrc
    import rxecrc_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_reset_n,
    rxecrc_if.slave   s
);

    rxc_state_t  r_state;
    logic [31:0] r_crc;
    logic [31:0] r_line;     // newest nibble at [31:28], oldest at [3:0]
    logic [3:0]  r_cnt;
    logic        r_wait_low; // after a cancel, ignore i_v until it drops
    logic        r_v;
    logic [3:0]  r_d;
    logic        r_done;
    logic        r_err;

    logic [31:0] w_crc_nxt;

    rxecrc_crc32_nib u_crc (
        .i_crc (r_crc),
        .i_nib (s.i_d),
        .o_crc (w_crc_nxt)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= RXC_IDLE;
            r_crc      <= CRC_INIT;
            r_line     <= 32'h0;
            r_cnt      <= 4'd0;
            r_wait_low <= 1'b0;
            r_v        <= 1'b0;
            r_d        <= 4'h0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else if (s.i_ce) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (s.i_cancel) begin
                r_state    <= RXC_IDLE;
                r_crc      <= CRC_INIT;
                r_line     <= 32'h0;
                r_cnt      <= 4'd0;
                r_v        <= 1'b0;
                // A cancel seen while i_v is already low needs no extra wait.
                r_wait_low <= s.i_v;
            end else begin
                case (r_state)
                    RXC_IDLE: begin
                        r_v <= 1'b0;
                        if (!s.i_v) begin
                            r_wait_low <= 1'b0;
                        end else if (!r_wait_low) begin
                            if (s.i_en) begin
                                r_line  <= {s.i_d, 28'h0};
                                r_cnt   <= 4'd1;
                                r_crc   <= w_crc_nxt;
                                r_state <= RXC_FILL;
                            end else begin
                                r_v     <= 1'b1;
                                r_d     <= s.i_d;
                                r_state <= RXC_BYPASS;
                            end
                        end
                    end
                    RXC_FILL: begin
                        r_v <= 1'b0;
                        if (s.i_v) begin
                            r_line <= {s.i_d, r_line[31:4]};
                            r_crc  <= w_crc_nxt;
                            r_cnt  <= r_cnt + 4'd1;
                            if (r_cnt == LINE_LAST)
                                r_state <= RXC_STREAM;
                        end else begin
                            // Ended before the FCS could even be collected.
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                            r_state <= RXC_IDLE;
                            r_crc   <= CRC_INIT;
                            r_cnt   <= 4'd0;
                            r_line  <= 32'h0;
                        end
                    end
                    RXC_STREAM: begin
                        if (s.i_v) begin
                            r_v    <= 1'b1;
                            r_d    <= r_line[3:0];
                            r_line <= {s.i_d, r_line[31:4]};
                            r_crc  <= w_crc_nxt;
                        end else begin
                            // Held nibbles are the FCS: drop them.
                            r_v     <= 1'b0;
                            r_done  <= 1'b1;
                            r_err   <= (r_crc != CRC_RESIDUE);
                            r_state <= RXC_IDLE;
                            r_crc   <= CRC_INIT;
                            r_cnt   <= 4'd0;
                            r_line  <= 32'h0;
                        end
                    end
                    RXC_BYPASS: begin
                        r_v <= s.i_v;
                        if (s.i_v) begin
                            r_d <= s.i_d;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= RXC_IDLE;
                        end
                    end
                    default: r_state <= RXC_IDLE;
                endcase
            end
        end
    end

    assign s.o_v    = r_v;
    assign s.o_d    = r_d;
    assign s.o_done = r_done;
    assign s.o_err  = r_err;

endmodule

// File: tb/tb_rxecrc.sv
// tb_rxecrc: directed bench for rxecrc. Frame 1 is ASCII "123456789" sent
// LSN first followed by its FCS (CRC-32 = CBF43926, bytes 26 39 F4 CB).
module tb_rxecrc;
    import rxecrc_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rxecrc_if bus ();

    rxecrc dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .s         (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] fr1 [0:25];
    logic [3:0] fr  [0:25];
    logic [3:0] q   [$];
    int         ndone;
    int         nerr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge, recorded only
    // on edges where ce was high so held values are not counted twice.
    task automatic tick(input logic ce);
        bus.i_ce = ce;
        @(posedge clk);
        #1;
        if (ce) begin
            if (bus.o_v)    q.push_back(bus.o_d);
            if (bus.o_done) ndone++;
            if (bus.o_err)  nerr++;
        end
    endtask

    task automatic ce_tick(input int div);
        for (int k = 0; k < div; k++) tick(k == div - 1);
    endtask

    task automatic clr();
        q.delete();
        ndone = 0;
        nerr  = 0;
    endtask

    task automatic send(input int n, input int div);
        for (int i = 0; i < n; i++) begin
            bus.i_v = 1'b1;
            bus.i_d = fr[i];
            ce_tick(div);
        end
        bus.i_v = 1'b0;
        for (int k = 0; k < 3; k++) ce_tick(div);
    endtask

    task automatic check_frame(input string tag, input int nout, input int edone, input int eerr);
        chk({tag, "_count"}, q.size(), nout);
        for (int i = 0; i < nout && i < q.size(); i++)
            chk({tag, "_data"}, {28'h0, q[i]}, {28'h0, fr[i]});
        chk({tag, "_done"}, ndone, edone);
        chk({tag, "_err"},  nerr,  eerr);
    endtask

    initial begin
        fr1 = '{4'h1,4'h3, 4'h2,4'h3, 4'h3,4'h3, 4'h4,4'h3, 4'h5,4'h3,
                4'h6,4'h3, 4'h7,4'h3, 4'h8,4'h3, 4'h9,4'h3,
                4'h6,4'h2, 4'h9,4'h3, 4'h4,4'hF, 4'hB,4'hC};
        fr  = fr1;
        bus.i_ce     = 1'b0;
        bus.i_en     = 1'b1;
        bus.i_cancel = 1'b0;
        bus.i_v      = 1'b0;
        bus.i_d      = 4'h0;
        clr();

        // Reset state
        #12;
        chk("rst_ov",   bus.o_v,    0);
        chk("rst_od",   bus.o_d,    0);
        chk("rst_done", bus.o_done, 0);
        chk("rst_err",  bus.o_err,  0);
        rst_n = 1'b1;
        ce_tick(1);
        ce_tick(1);

        // 1: good frame, with latency check after first 8 nibbles
        clr();
        for (int i = 0; i < 8; i++) begin
            bus.i_v = 1'b1;
            bus.i_d = fr[i];
            ce_tick(1);
        end
        chk("lat_fill", q.size(), 0);
        bus.i_d = fr[8];
        ce_tick(1);
        chk("lat_first", q.size(), 1);
        for (int i = 9; i < 26; i++) begin
            bus.i_d = fr[i];
            ce_tick(1);
        end
        bus.i_v = 1'b0;
        for (int k = 0; k < 3; k++) ce_tick(1);
        check_frame("good", 18, 1, 0);

        // 2: payload nibble 5 flipped 3->2
        clr();
        fr[5] = 4'h2;
        send(26, 1);
        check_frame("bad", 18, 1, 1);
        fr = fr1;

        // 3: runt
        clr();
        send(6, 1);
        check_frame("runt", 0, 1, 1);

        // 4: cancel at nibble 12, i_v kept high a while after
        clr();
        for (int i = 0; i < 12; i++) begin
            bus.i_v = 1'b1;
            bus.i_d = fr[i];
            ce_tick(1);
        end
        chk("pre_cancel_ov", bus.o_v, 1);
        bus.i_cancel = 1'b1;
        bus.i_d      = fr[12];
        ce_tick(1);
        chk("cancel_ov", bus.o_v, 0);
        bus.i_cancel = 1'b0;
        for (int i = 13; i < 16; i++) begin
            bus.i_d = fr[i];
            ce_tick(1);
        end
        bus.i_v = 1'b0;
        for (int k = 0; k < 3; k++) ce_tick(1);
        chk("cancel_out",  q.size(), 4);
        chk("cancel_done", ndone, 0);
        chk("cancel_err",  nerr,  0);
        clr();
        send(26, 1);
        check_frame("post_cancel", 18, 1, 0);

        // 5: ce one cycle in four
        clr();
        send(26, 4);
        check_frame("ce4", 18, 1, 0);
        clr();
        fr[5] = 4'h2;
        send(26, 4);
        check_frame("ce4_bad", 18, 1, 1);
        fr = fr1;

        // 6a: bypass
        bus.i_en = 1'b0;
        clr();
        send(26, 1);
        check_frame("bypass", 26, 1, 0);
        bus.i_en = 1'b1;

        // 6b: async reset mid-frame
        clr();
        for (int i = 0; i < 10; i++) begin
            bus.i_v = 1'b1;
            bus.i_d = fr[i];
            ce_tick(1);
        end
        chk("pre_rst_ov", bus.o_v, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ov",   bus.o_v,    0);
        chk("arst_od",   bus.o_d,    0);
        chk("arst_done", bus.o_done, 0);
        chk("arst_err",  bus.o_err,  0);
        bus.i_v = 1'b0;
        ce_tick(1);
        ce_tick(1);
        #2;
        rst_n = 1'b1;
        ce_tick(1);
        clr();
        send(26, 1);
        check_frame("post_rst", 18, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
